coin_start_seq: RTL and testbench

COIN_START_SEQ -- requirements
Module: coin_start_seq

---
 rtl/coin_start_seq_pkg.sv | 35 +++
 rtl/coin_start_seq_if.sv | 12 +
 rtl/cseq_frame_timer.sv | 29 ++
 rtl/coin_start_seq.sv | 164 ++++++++++++++++
 tb/tb_coin_start_seq.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/coin_start_seq_pkg.sv
// Shared types and constants for the coin/start sequencer.
package cseq_pkg;

  localparam int unsigned CNT_W              = 8;
  localparam int unsigned DEF_COIN_FRAMES    = 4;
  localparam int unsigned DEF_GAP_FRAMES     = 8;
  localparam int unsigned DEF_START_FRAMES   = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COIN    = 3'd1,
    GAP     = 3'd2,
    START   = 3'd3,
    HOLDOFF = 3'd4
  } cseq_state_e;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_P1   = 2'd1,
    TGT_P2   = 2'd2
  } cseq_tgt_e;

  // One-hot select pattern for a target player; none selects nothing.
  function automatic logic [1:0] tgt_select(input cseq_tgt_e t);
    logic [1:0] sel;
    sel = 2'b00;
    case (t)
      TGT_P1:  sel = 2'b01;
      TGT_P2:  sel = 2'b10;
      default: sel = 2'b00;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/coin_start_seq_if.sv
// Pad-side bundle of the sequencer: button/frame inputs and game-core lines.
interface coin_start_seq_if;
  logic       i_frame;
  logic [1:0] i_start;
  logic       i_coin;
  logic       o_coin;
  logic [1:0] o_select;
  logic       o_busy;

  modport master (output i_frame, i_start, i_coin, input o_coin, o_select, o_busy);
  modport slave  (input i_frame, i_start, i_coin, output o_coin, o_select, o_busy);
endinterface

// File: rtl/cseq_frame_timer.sv
// Frame counter shared by all timed phases: load on entry, count down on frames.
module cseq_frame_timer
  import cseq_pkg::*;
(
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             done_c
);

  logic [CNT_W-1:0] count;

  // Load has priority, so a frame in the load cycle is never counted; no wrap below zero.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  // Final frame of the phase.
  assign done_c = tick && (count == CNT_W'(1));

endmodule

// File: rtl/coin_start_seq.sv
// Coin/start sequencer: turns a start press into coin -> gap -> select pulses.
// Build option CSEQ_AUTO_COIN_EN: when defined a start press inserts a coin
// pulse first; otherwise a start press goes straight to the gap phase.
module coin_start_seq
  import cseq_pkg::*;
#(
  parameter int unsigned COIN_FRAMES  = DEF_COIN_FRAMES,
  parameter int unsigned GAP_FRAMES   = DEF_GAP_FRAMES,
  parameter int unsigned START_FRAMES = DEF_START_FRAMES
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       i_frame,
  input  logic [1:0] i_start,
  input  logic       i_coin,
  output logic       o_coin,
  output logic [1:0] o_select,
  output logic       o_busy
);

`ifdef CSEQ_AUTO_COIN_EN
  localparam cseq_state_e      JOB_ST  = COIN;
  localparam logic [CNT_W-1:0] JOB_LEN = CNT_W'(COIN_FRAMES);
`else
  localparam cseq_state_e      JOB_ST  = GAP;
  localparam logic [CNT_W-1:0] JOB_LEN = CNT_W'(GAP_FRAMES);
`endif

  logic             frame_q;
  logic [1:0]       start_q;
  logic             coin_q;
  logic             sample_vld;
  logic [1:0]       start_low;
  logic             coin_low;
  logic [1:0]       start_edge_c;
  logic             coin_edge_c;

  cseq_state_e      state, state_nx;
  cseq_tgt_e        target, target_nx;
  logic [1:0]       pend, pend_nx;
  logic             tmr_load_c;
  logic [CNT_W-1:0] tmr_val_c;
  logic             tmr_done_c;

  // Input sampling; the "was low" flags only arm from a genuine post-reset sample.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      frame_q    <= 1'b0;
      start_q    <= 2'b00;
      coin_q     <= 1'b0;
      sample_vld <= 1'b0;
      start_low  <= 2'b00;
      coin_low   <= 1'b0;
    end else begin
      frame_q    <= i_frame;
      start_q    <= i_start;
      coin_q     <= i_coin;
      sample_vld <= 1'b1;
      start_low  <= {2{sample_vld}} & ~start_q;
      coin_low   <= sample_vld & ~coin_q;
    end
  end

  assign start_edge_c = start_q & start_low;
  assign coin_edge_c  = coin_q & coin_low;

  cseq_frame_timer u_timer (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .tick     (frame_q),
    .done_c   (tmr_done_c)
  );

  // State, target, pending and registered outputs derived from the next state.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      target   <= TGT_NONE;
      pend     <= 2'b00;
      o_coin   <= 1'b0;
      o_select <= 2'b00;
      o_busy   <= 1'b0;
    end else begin
      state    <= state_nx;
      target   <= target_nx;
      pend     <= pend_nx;
      o_coin   <= (state_nx == COIN);
      o_select <= (state_nx == START) ? tgt_select(target_nx) : 2'b00;
      o_busy   <= (state_nx != IDLE);
    end
  end

  // Next-state logic; P1 always wins a tie, the loser waits in its pending bit.
  always_comb begin
    state_nx   = state;
    target_nx  = target;
    pend_nx    = pend;
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;
    case (state)
      IDLE: begin
        if (start_edge_c != 2'b00) begin
          target_nx  = start_edge_c[0] ? TGT_P1 : TGT_P2;
          pend_nx    = pend | {start_edge_c[0] & start_edge_c[1], 1'b0};
          state_nx   = JOB_ST;
          tmr_load_c = 1'b1;
          tmr_val_c  = JOB_LEN;
        end else if (coin_edge_c) begin
          target_nx  = TGT_NONE;
          state_nx   = COIN;
          tmr_load_c = 1'b1;
          tmr_val_c  = CNT_W'(COIN_FRAMES);
        end
      end
      COIN: begin
        pend_nx = pend | start_edge_c;
        if (tmr_done_c) begin
          if (target != TGT_NONE) begin
            state_nx   = GAP;
            tmr_load_c = 1'b1;
            tmr_val_c  = CNT_W'(GAP_FRAMES);
          end else begin
            state_nx = IDLE;
          end
        end
      end
      GAP: begin
        pend_nx = pend | start_edge_c;
        if (tmr_done_c) begin
          state_nx   = START;
          tmr_load_c = 1'b1;
          tmr_val_c  = CNT_W'(START_FRAMES);
        end
      end
      START: begin
        pend_nx = pend | start_edge_c;
        if (tmr_done_c) begin
          state_nx = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (start_q == 2'b00) begin
          if (pend[0] || pend[1]) begin
            target_nx  = pend[0] ? TGT_P1 : TGT_P2;
            pend_nx    = pend[0] ? {pend[1], 1'b0} : 2'b00;
            state_nx   = JOB_ST;
            tmr_load_c = 1'b1;
            tmr_val_c  = JOB_LEN;
          end else begin
            target_nx = TGT_NONE;
            state_nx  = IDLE;
          end
        end
      end
      default: begin
        target_nx = TGT_NONE;
        state_nx  = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_coin_start_seq.sv
// Scoreboard bench for coin_start_seq (COIN=2, GAP=3, START=2).
// Driver feeds a phase-queue reference model; monitor compares every output change.
module tb_coin_start_seq;

  localparam int COIN_N  = 2;
  localparam int GAP_N   = 3;
  localparam int START_N = 2;

  typedef struct packed {
    logic       coin;
    logic [1:0] sel;
    logic       busy;
  } out_t;

  typedef struct {
    int unsigned cyc;
    out_t        val;
  } exp_t;

  typedef enum {PH_COIN, PH_GAP, PH_START, PH_HOLD} ph_e;

  typedef struct {
    ph_e kind;
    int  frames;
  } ph_t;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;

  coin_start_seq_if pad();

  coin_start_seq #(
    .COIN_FRAMES  (COIN_N),
    .GAP_FRAMES   (GAP_N),
    .START_FRAMES (START_N)
  ) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .i_frame  (pad.i_frame),
    .i_start  (pad.i_start),
    .i_coin   (pad.i_coin),
    .o_coin   (pad.o_coin),
    .o_select (pad.o_select),
    .o_busy   (pad.o_busy)
  );

  always #5 clk_sys = ~clk_sys;

  exp_t        expq[$];
  ph_t         phq[$];
  int          cur;
  logic [1:0]  pend;
  logic [1:0]  prev_low;
  logic        prev_low_coin;
  bit          prev_vld;
  out_t        mout, mout_prev;
  int unsigned cnt = 0;
  int          checks = 0;
  int          failures = 0;

  // Expected pad outputs from the head of the phase queue.
  function automatic out_t model_out();
    out_t o;
    o = '0;
    if (phq.size() != 0) begin
      o.busy = 1'b1;
      if (phq[0].kind == PH_COIN)  o.coin = 1'b1;
      if (phq[0].kind == PH_START) o.sel = (cur == 1) ? 2'b01 : 2'b10;
    end
    return o;
  endfunction

  task automatic model_reset();
    phq.delete();
    cur = 0; pend = 2'b00; prev_low = 2'b00; prev_low_coin = 1'b0;
    prev_vld = 1'b0; mout = '0; mout_prev = '0;
  endtask

  // A player's job: optional coin, gap, select, then wait for release.
  task automatic start_job(input int p);
    cur = p;
`ifdef CSEQ_AUTO_COIN_EN
    phq.push_back('{kind: PH_COIN, frames: COIN_N});
`endif
    phq.push_back('{kind: PH_GAP,   frames: GAP_N});
    phq.push_back('{kind: PH_START, frames: START_N});
    phq.push_back('{kind: PH_HOLD,  frames: 0});
  endtask

  // One sampled cycle of inputs; the resulting outputs show two edges later.
  task automatic model_step(input logic [1:0] s, input logic c, input logic f);
    logic [1:0] es;
    logic       ec;
    es = prev_vld ? (s & prev_low) : 2'b00;
    ec = prev_vld ? (c & prev_low_coin) : 1'b0;
    prev_vld = 1'b1; prev_low = ~s; prev_low_coin = ~c;
    if (phq.size() == 0) begin
      if (es != 2'b00) begin
        if (es[0]) begin
          start_job(1);
          if (es[1]) pend[1] = 1'b1;
        end else begin
          start_job(2);
        end
      end else if (ec) begin
        cur = 0;
        phq.push_back('{kind: PH_COIN, frames: COIN_N});
      end
    end else if (phq[0].kind == PH_HOLD) begin
      if (s == 2'b00) begin
        phq.delete(0);
        if (pend[0]) begin pend[0] = 1'b0; start_job(1); end
        else if (pend[1]) begin pend[1] = 1'b0; start_job(2); end
        else cur = 0;
      end
    end else begin
      pend = pend | es;
      if (f) begin
        phq[0].frames = phq[0].frames - 1;
        if (phq[0].frames == 0) begin
          phq.delete(0);
          if (phq.size() == 0) cur = 0;
        end
      end
    end
    mout_prev = mout;
    mout = model_out();
    if (mout != mout_prev) expq.push_back('{cyc: cnt + 2, val: mout});
  endtask

  task automatic drive(input logic [1:0] s, input logic c, input logic f);
    @(negedge clk_sys);
    pad.i_start = s; pad.i_coin = c; pad.i_frame = f;
    if (reset_n) model_step(s, c, f);
  endtask

  task automatic run(input logic [1:0] s, input logic c, input int n, input int per);
    for (int i = 0; i < n; i++) drive(s, c, (i % per) == (per - 1));
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (pad.o_coin !== 1'b0 || pad.o_select !== 2'b00 || pad.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s coin=%b sel=%b busy=%b required all 0", name, pad.o_coin, pad.o_select, pad.o_busy);
    end
  endtask

  // Assert reset between edges, holding i_start, then release with it still held.
  task automatic reset_mid(input logic [1:0] s, input int n);
    @(negedge clk_sys);
    reset_n = 1'b0; pad.i_start = s; pad.i_coin = 1'b0; pad.i_frame = 1'b0;
    while (expq.size() != 0 && expq[expq.size() - 1].cyc > cnt) expq.delete(expq.size() - 1);
    if (mout_prev != '0) expq.push_back('{cyc: cnt + 1, val: out_t'(4'b0000)});
    model_reset();
    #1;
    check_zero("reset_async");
    repeat (n) @(negedge clk_sys);
    reset_n = 1'b1;
    model_step(s, 1'b0, 1'b0);
  endtask

  // Monitor: each output change must match the next expected change and cycle.
  initial begin : monitor
    out_t seen, last;
    exp_t e;
    last = '0;
    forever begin
      @(posedge clk_sys);
      cnt++;
      #1;
      seen = {pad.o_coin, pad.o_select, pad.o_busy};
      checks++;
      if ((seen.coin && seen.sel != 2'b00) || seen.sel == 2'b11) begin
        failures++;
        $display("FAIL exclusive cyc=%0d coin=%b sel=%b required coin and one-hot sel never together", cnt, seen.coin, seen.sel);
      end
      while (expq.size() != 0 && expq[0].cyc < cnt) begin
        e = expq.pop_front();
        checks++; failures++;
        $display("FAIL missed_change cyc=%0d expected %b at cyc=%0d, outputs stayed %b", cnt, e.val, e.cyc, seen);
      end
      if (seen != last) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change cyc=%0d got=%b required no change from %b", cnt, seen, last);
        end else begin
          e = expq.pop_front();
          if (e.val != seen || e.cyc != cnt) begin
            failures++;
            $display("FAIL out_change got=%b at cyc=%0d required=%b at cyc=%0d", seen, cnt, e.val, e.cyc);
          end
        end
        last = seen;
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic, then drain.
  initial begin : stim
    logic [1:0] rs;
    logic       rc;
    rs = 2'b00; rc = 1'b0;
    pad.i_start = 2'b00; pad.i_coin = 1'b0; pad.i_frame = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_sys);
    check_zero("reset_state");
    @(negedge clk_sys);
    reset_n = 1'b1;
    model_step(2'b00, 1'b0, 1'b0);
    run(2'b00, 1'b0, 4, 3);

    // single P1 press, held into the hold-off phase, then released
    drive(2'b01, 1'b0, 1'b0);
    run(2'b01, 1'b0, 30, 3);
    run(2'b00, 1'b0, 10, 3);

    // both players in one cycle: P1 runs, P2 follows after release
    drive(2'b11, 1'b0, 1'b0);
    run(2'b11, 1'b0, 25, 3);
    run(2'b00, 1'b0, 45, 3);

    // manual coin, with a second coin press during the coin pulse
    drive(2'b00, 1'b1, 1'b0);
    run(2'b00, 1'b1, 2, 3);
    drive(2'b00, 1'b0, 1'b0);
    drive(2'b00, 1'b1, 1'b0);
    run(2'b00, 1'b0, 15, 3);

    // frame strobe in the same cycle as the start edge is not counted
    drive(2'b01, 1'b0, 1'b1);
    run(2'b01, 1'b0, 25, 3);
    run(2'b00, 1'b0, 12, 3);

    // P2 alone
    drive(2'b10, 1'b0, 1'b0);
    run(2'b10, 1'b0, 25, 4);
    run(2'b00, 1'b0, 8, 4);

    // reset during the gap with start held through release: nothing starts
    drive(2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 60 && !(phq.size() != 0 && phq[0].kind == PH_GAP); i++)
      drive(2'b01, 1'b0, (i % 3) == 2);
    reset_mid(2'b01, 3);
    run(2'b01, 1'b0, 12, 3);
    run(2'b00, 1'b0, 6, 3);

    // randomized traffic with one reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) reset_mid(rs, 2);
      if ($urandom_range(7) == 0)  rs[0] = ~rs[0];
      if ($urandom_range(7) == 0)  rs[1] = ~rs[1];
      if ($urandom_range(15) == 0) rc = ~rc;
      drive(rs, rc, $urandom_range(3) == 0);
    end

    // drain back to idle
    for (int i = 0; i < 400 && phq.size() != 0; i++)
      drive(2'b00, 1'b0, (i % 3) == 2);
    run(2'b00, 1'b0, 5, 3);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain pending_expected=%0d required 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
